// File: rtl/riscv_pipe_pkg.sv
// Shared IF-stage types and constants for the fetch redirect controller.
package riscv_pipe_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;
  localparam int DRAIN_CNT_W = 3;

endpackage

// File: rtl/redirect_edge_detect.sv
// Registers the branch-control redirect level and produces the one-shot
// acceptance pulse, qualified by flush and the fetch FSM being in RUN.
module redirect_edge_detect import riscv_pipe_pkg::*; (
  input  logic clk,
  input  logic reset,
  input  logic redirect,
  input  logic flush,
  input  logic in_run,
  output logic acc
);

  logic redirect_q;

  always_ff @(posedge clk) begin
    if (reset) redirect_q <= 1'b0;
    else       redirect_q <= redirect;
  end

  // Rising edge only: a redirect held high across many cycles is taken once.
  assign acc = redirect & flush & ~redirect_q & in_run & ~reset;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner: steers to branch targets, squashes IF/ID and ID/EX, and
// drains the synchronous imem. REDIRECT_PERF_EN adds the redirect_count port.
module fetch_redirect_ctrl import riscv_pipe_pkg::*; #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  // redirect and flush are levels, not a valid/ready pair: a redirect is
  // taken on its first high cycle with flush high while in RUN; there is no
  // back-pressure, and anything seen during DRAIN is dropped.
  input  logic            redirect,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] pc,
  output logic            fetch_valid,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            misalign_err,
  output fetch_state_e    dbg_state
`ifdef REDIRECT_PERF_EN
  ,
  output logic [31:0]     redirect_count
`endif
);

  fetch_state_e           state, state_next;
  logic [XLEN-1:0]        pc_next;
  logic [DRAIN_CNT_W-1:0] cnt, cnt_next;
  logic                   misalign_next;
  logic                   acc;

  redirect_edge_detect u_edge (
    .clk      (clk),
    .reset    (reset),
    .redirect (redirect),
    .flush    (flush),
    .in_run   (state == RUN),
    .acc      (acc)
  );

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    cnt_next      = cnt;
    misalign_next = 1'b0;
    case (state)
      RUN: begin
        if (acc) begin
          pc_next       = {redirect_target[XLEN-1:2], 2'b00};
          state_next    = DRAIN;
          cnt_next      = DRAIN_CNT_W'(FLUSH_CYCLES - 1);
          misalign_next = |redirect_target[1:0];
        end else if (!stall) begin
          pc_next = pc + XLEN'(INSTR_BYTES);
        end
      end
      DRAIN: begin
        // The target fetch completes as we leave, so RUN resumes at target+4.
        if (!stall) begin
          if (cnt != '0) begin
            cnt_next = cnt - DRAIN_CNT_W'(1);
          end else begin
            state_next = RUN;
            pc_next    = pc + XLEN'(INSTR_BYTES);
          end
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      pc           <= RESET_PC;
      cnt          <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      cnt          <= cnt_next;
      misalign_err <= misalign_next;
    end
  end

`ifdef REDIRECT_PERF_EN
  always_ff @(posedge clk) begin
    if (reset)
      redirect_count <= '0;
    else if (acc && (redirect_count != 32'hFFFF_FFFF))
      redirect_count <= redirect_count + 32'd1;
  end
`endif

  assign fetch_valid = (state == RUN) & ~reset;
  assign id_ex_flush = acc;
  assign if_id_flush = (acc | (state == DRAIN)) & ~reset;
  assign dbg_state   = state;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed vectors with literal expectations
// plus a per-cycle comparison against a timeline model of fetch redirects.
module tb_fetch_redirect_ctrl;
  import riscv_pipe_pkg::*;

  localparam int          XLEN         = 64;
  localparam logic [63:0] RESET_PC     = 64'h0;
  localparam int          FLUSH_CYCLES = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] redirect_target = '0;

  logic [63:0]  pc;
  logic         fetch_valid;
  logic         if_id_flush;
  logic         id_ex_flush;
  logic         misalign_err;
  fetch_state_e dbg_state;
`ifdef REDIRECT_PERF_EN
  logic [31:0]  redirect_count;
`endif

  fetch_redirect_ctrl #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .flush           (flush),
    .redirect_target (redirect_target),
    .pc              (pc),
    .fetch_valid     (fetch_valid),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .misalign_err    (misalign_err),
    .dbg_state       (dbg_state)
`ifdef REDIRECT_PERF_EN
    ,
    .redirect_count  (redirect_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // model: fetch is blind for m_left more unstalled cycles after a redirect
  logic [63:0] m_pc   = RESET_PC;
  int          m_left = 0;
  logic        m_prev = 1'b0;
  logic        m_mis  = 1'b0;
  logic [31:0] m_cnt  = '0;
  bit          armed  = 1'b0;

  always @(negedge clk) begin : compare
    logic in_drain, exp_acc, exp_fv, exp_ifid;
    in_drain = (m_left != 0);
    exp_acc  = redirect & flush & ~m_prev & ~in_drain & ~reset;
    exp_fv   = ~in_drain & ~reset;
    exp_ifid = (exp_acc | in_drain) & ~reset;
    if (armed) begin
      chk("m_pc", pc, m_pc);
      chk("m_fetch_valid", fetch_valid, exp_fv);
      chk("m_if_id_flush", if_id_flush, exp_ifid);
      chk("m_id_ex_flush", id_ex_flush, exp_acc);
      chk("m_misalign_err", misalign_err, m_mis);
      chk("m_dbg_drain", dbg_state == DRAIN, in_drain);
`ifdef REDIRECT_PERF_EN
      chk("m_redirect_count", redirect_count, m_cnt);
`endif
    end
    if (reset) begin
      m_pc = RESET_PC; m_left = 0; m_prev = 1'b0; m_mis = 1'b0; m_cnt = '0;
      armed = 1'b1;
    end else begin
      m_prev = redirect;
      m_mis  = 1'b0;
      if (exp_acc) begin
        m_pc   = redirect_target & ~64'h3;
        m_left = FLUSH_CYCLES;
        m_mis  = (redirect_target[1:0] != 2'b00);
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end else if (in_drain) begin
        if (!stall) begin
          m_left = m_left - 1;
          if (m_left == 0) m_pc = m_pc + 64'd4;
        end
      end else if (!stall) begin
        m_pc = m_pc + 64'd4;
      end
    end
  end

  // driver: apply one cycle of inputs, leave time to check that cycle
  task automatic cyc(input logic r, input logic f, input logic s, input logic rst,
                     input logic [63:0] tgt);
    @(posedge clk);
    #1;
    redirect = r; flush = f; stall = s; reset = rst; redirect_target = tgt;
    #3;
  endtask

  initial begin
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("rst_pc", pc, 64'h0);
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_if_id_flush", if_id_flush, 0);
    chk("rst_id_ex_flush", id_ex_flush, 0);

    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("seq_pc", pc, 64'(4 * i));
      chk("seq_fetch_valid", fetch_valid, 1);
      chk("seq_if_id_flush", if_id_flush, 0);
      chk("seq_id_ex_flush", id_ex_flush, 0);
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);

    // basic redirect from 0x20 to 0x100
    cyc(1, 1, 0, 0, 64'h100);
    chk("redir_pc", pc, 64'h20);
    chk("redir_id_ex", id_ex_flush, 1);
    chk("redir_if_id", if_id_flush, 1);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("drain_pc", pc, 64'h100);
      chk("drain_fetch_valid", fetch_valid, 0);
      chk("drain_if_id", if_id_flush, 1);
    end
    cyc(0, 0, 0, 0, 0);
    chk("resume_pc", pc, 64'h104);
    chk("resume_fetch_valid", fetch_valid, 1);

    // held-high redirect accepted once
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, 0, 64'h200);
      if (i == 0) chk("held_acc", id_ex_flush, 1);
      if (i == 1 || i == 2) chk("held_drain_fv", fetch_valid, 0);
      if (i == 3) chk("held_pc3", pc, 64'h204);
      if (i >= 3) chk("held_no_reacc", id_ex_flush, 0);
    end
    cyc(0, 0, 0, 0, 0);
    chk("held_after_pc", pc, 64'h20C);
`ifdef REDIRECT_PERF_EN
    chk("held_count", redirect_count, 32'd2);
`endif

    // stall in first drain cycle stretches drain to 3 cycles
    cyc(1, 1, 0, 0, 64'h100);
    chk("stall_redir_pc", pc, 64'h210);
    cyc(0, 0, 1, 0, 0);
    chk("stall_d1_pc", pc, 64'h100);
    chk("stall_d1_fv", fetch_valid, 0);
    cyc(0, 0, 0, 0, 0);
    chk("stall_d2_pc", pc, 64'h100);
    chk("stall_d2_fv", fetch_valid, 0);
    cyc(0, 0, 0, 0, 0);
    chk("stall_d3_pc", pc, 64'h100);
    chk("stall_d3_fv", fetch_valid, 0);
    cyc(0, 0, 0, 0, 0);
    chk("stall_resume_pc", pc, 64'h104);
    chk("stall_resume_fv", fetch_valid, 1);

    // misaligned target
    cyc(1, 1, 0, 0, 64'h102);
    chk("mis_before", misalign_err, 0);
    cyc(0, 0, 0, 0, 0);
    chk("mis_pc", pc, 64'h100);
    chk("mis_pulse", misalign_err, 1);
    cyc(0, 0, 0, 0, 0);
    chk("mis_cleared", misalign_err, 0);
    cyc(0, 0, 0, 0, 0);
    chk("mis_resume_pc", pc, 64'h104);

    // reset in second drain cycle
    cyc(1, 1, 0, 0, 64'h300);
    cyc(0, 0, 0, 0, 0);
    chk("rstd_pc", pc, 64'h300);
    cyc(0, 0, 0, 1, 0);
    chk("rstd_fv", fetch_valid, 0);
    chk("rstd_if_id", if_id_flush, 0);
    chk("rstd_id_ex", id_ex_flush, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rstd_after_pc", pc, 64'h0);
    chk("rstd_after_fv", fetch_valid, 1);
    chk("rstd_after_drain", dbg_state == DRAIN, 0);
`ifdef REDIRECT_PERF_EN
    chk("rstd_count", redirect_count, 32'd0);
`endif

    // redirect without flush is ignored
    cyc(1, 0, 0, 0, 64'h400);
    chk("noflush_id_ex", id_ex_flush, 0);
    cyc(0, 0, 0, 0, 0);
    chk("noflush_pc", pc, 64'h8);

    // redirect during drain is ignored
    cyc(1, 1, 0, 0, 64'h500);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 64'h600);
    chk("indrain_id_ex", id_ex_flush, 0);
    chk("indrain_pc", pc, 64'h500);
    cyc(0, 0, 0, 0, 0);
    chk("indrain_resume_pc", pc, 64'h504);

    // pc wrap
    cyc(1, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("wrap_top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(0, 0, 0, 0, 0);
    chk("wrap_zero_pc", pc, 64'h0);
    chk("wrap_fv", fetch_valid, 1);

    // mixed traffic, checked by the model only
    for (int i = 0; i < 300; i++) begin
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 50) == 0,
          {32'($urandom), 32'($urandom)});
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

- Consumes the branch-resolution outputs `Switch_Branch` and `Flush` and owns the fetch program counter.
- On an accepted redirect it:
  - steers the PC to the branch target;
  - squashes the IF/ID and ID/EX pipeline registers;
  - holds fetch invalid for a fixed drain window while the synchronous instruction memory refills.
- Sits in the IF stage, between the EX-stage branch logic and the instruction memory and pipeline registers.

## Interface

Parameters:
- XLEN, 64: PC and target width.
- RESET_PC, 0: PC value loaded on reset.
- FLUSH_CYCLES, 2: fetch-invalid drain cycles after a redirect; legal range 1..7.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; holds PC and freezes drain counter.
- redirect  in  1  level from branch control (`Switch_Branch`); may stay high for several cycles.
- flush  in  1  level from branch control (`Flush`); qualifies redirect.
- redirect_target  in  XLEN  branch target from EX.
- pc  out  XLEN  current fetch address to instruction memory.
- fetch_valid  out  1  instruction fetched at pc is usable.
- if_id_flush  out  1  clear IF/ID register this cycle.
- id_ex_flush  out  1  clear ID/EX register this cycle.
- misalign_err  out  1  one-cycle pulse: accepted target had target[1:0] != 0.
- redirect_count  out  32  accepted-redirect counter (only with REDIRECT_PERF_EN).

## Operation

States:
- RUN: normal sequential fetch.
- DRAIN: waiting out instruction-memory latency after a redirect.

Redirect acceptance:
- `acc = redirect & flush & ~redirect_q & (state==RUN) & ~reset`.
- redirect_q is redirect registered every cycle; reset clears it.
- A held-high redirect is therefore accepted once only.
- Any redirect seen in DRAIN is ignored.

RUN behaviour:
- acc=1:
  - pc <= {redirect_target[XLEN-1:2], 2'b00};
  - state <= DRAIN;
  - cnt <= FLUSH_CYCLES-1;
  - misalign_err <= (redirect_target[1:0] != 0).
- acc=0, stall=0: pc <= pc + 4, wrapping modulo 2^XLEN.
- acc=0, stall=1: pc holds.
- Redirect has priority over stall.

DRAIN behaviour:
- pc holds the target.
- stall=1: cnt holds.
- stall=0, cnt!=0: cnt decrements.
- stall=0, cnt==0: state <= RUN and pc <= pc + 4.
- Because the fetch issued at the target address during drain is the one that completes, fetch_valid rises with pc = target + 4. The instruction memory holds the target instruction word at that point.

Outputs:
- fetch_valid = (state==RUN) & ~reset.
- id_ex_flush = acc (combinational).
- if_id_flush = acc | (state==DRAIN).
- misalign_err is registered and cleared the following cycle.

Reset:
- Reset takes priority over all inputs.
- pc=RESET_PC, state=RUN, cnt=0, redirect_q=0, misalign_err=0, redirect_count=0.
- While reset is high, fetch_valid, if_id_flush and id_ex_flush are 0.
- Reset asserted mid-DRAIN aborts the drain. The first cycle after release is RUN with pc=RESET_PC.

## Timing

- Redirect latency: redirect high in cycle N → pc=target in cycle N+1.
- id_ex_flush and if_id_flush are high in cycle N; if_id_flush stays high through DRAIN.
- Unstalled drain: cycles N+1..N+FLUSH_CYCLES are DRAIN. fetch_valid=1 from N+FLUSH_CYCLES+1.
- Each stall cycle during DRAIN extends it by one cycle.
- Redirect re-acceptance needs redirect low for at least one cycle while in RUN.
- PC wrap: 0xFFFF_FFFF_FFFF_FFFC + 4 → 0, with no flag.

## Configuration

- Macro `REDIRECT_PERF_EN`.
- Defined:
  - redirect_count port exists;
  - it increments on each cycle with acc=1;
  - it saturates at 32'hFFFF_FFFF;
  - reset clears it.
- Undefined: the port and counter logic are absent. All other behaviour is identical.

## Structure

- Shared package `riscv_pipe_pkg` holds:
  - the state enum (RUN, DRAIN);
  - INSTR_BYTES = 4;
  - DRAIN_CNT_W = 3.
- One sub-module, `redirect_edge_detect`: registers redirect and produces the one-shot acceptance pulse, gated by flush and state.
- The PC register, drain counter and FSM stay in the top module.

## Test plan

- Reset release, RESET_PC=0, no stall, 4 cycles → pc 0,4,8,12; fetch_valid=1; all flush outputs 0.
- redirect=flush=1 for one cycle at pc=0x20, target=0x100 → that cycle: id_ex_flush=if_id_flush=1. Next 2 cycles: pc=0x100, fetch_valid=0, if_id_flush=1. Then fetch_valid=1 with pc=0x104.
- redirect held high 5 cycles, target=0x200 → exactly one acceptance; DRAIN lasts 2 cycles; redirect_count increments by 1.
- stall=1 during first DRAIN cycle → DRAIN lasts 3 cycles; pc stays 0x100 throughout.
- target=0x102 → pc=0x100; misalign_err pulses exactly one cycle.
- reset asserted in second DRAIN cycle → next cycle after release: state RUN, pc=0, fetch_valid=1, redirect_count=0.
